// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS main control FSM
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [3:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MA   = 4'd3,
    S_MR   = 4'd4,
    S_WBM  = 4'd5,
    S_MW   = 4'd6,
    S_EXR  = 4'd7,
    S_WBR  = 4'd8,
    S_EXI  = 4'd9,
    S_WBI  = 4'd10,
    S_BR   = 4'd11,
    S_JMP  = 4'd12,
    S_JR   = 4'd13,
    S_HALT = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  state_t state_q, state_d;

  logic is_jr_fn;
  logic is_shift_fn;

  assign is_jr_fn    = (Funct == FN_JR) || (Funct == FN_JALR);
  assign is_shift_fn = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);
  assign State       = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    ALUOp       = 4'b0000;
    Illegal     = 1'b0;

    case (state_q)
      S_RST: state_d = S_IF;

      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        state_d = S_ID;
      end

      // Speculatively compute the branch target into ALUOut while decoding.
      S_ID: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MA;
          OP_RTYPE:     state_d = is_jr_fn ? S_JR : S_EXR;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                        state_d = S_EXI;
          OP_BEQ:       state_d = S_BR;
          OP_J, OP_JAL: state_d = S_JMP;
          default: begin
            Illegal = 1'b1;
            state_d = ILLEGAL_HALT ? S_HALT : S_IF;
          end
        endcase
      end

      S_MA: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        state_d = (OpCode == OP_LW) ? S_MR : S_MW;
      end

      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_WBM;
      end

      S_WBM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        state_d  = S_IF;
      end

      S_MW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_IF;
      end

      S_EXR: begin
        ALUSrcA = is_shift_fn ? 2'b10 : 2'b01;
        ALUOp   = 4'b0010;
        state_d = S_WBR;
      end

      S_WBR: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_IF;
      end

      // andi zero-extends; everything else sign-extends its immediate.
      S_EXI: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = (OpCode != OP_ANDI);
        LuiOp   = (OpCode == OP_LUI);
        case (OpCode)
          OP_ADDIU: ALUOp = 4'b1000;
          OP_ANDI:  ALUOp = 4'b0100;
          OP_SLTI:  ALUOp = 4'b0101;
          OP_SLTIU: ALUOp = 4'b1101;
          default:  ALUOp = 4'b0000;
        endcase
        state_d = S_WBI;
      end

      S_WBI: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end

      S_BR: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 4'b0001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_IF;
      end

      // PC was already advanced in IF, so the link value is simply PC.
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        state_d = S_IF;
      end

      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          MemtoReg = 2'b10;
        end
        state_d = S_IF;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, irw, rw, ext, lui;
    logic [1:0] srca, srcb, pcsrc, m2r, rdst;
    logic [3:0] aluop;
    logic       ill;
    logic [3:0] st;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;

  logic       pcw0, pcwc0, iord0, mr0, mw0, irw0, rw0, ext0, lui0, ill0;
  logic [1:0] srca0, srcb0, pcsrc0, m2r0, rdst0;
  logic [3:0] aluop0, state0;
  logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, rw1, ext1, lui1, ill1;
  logic [1:0] srca1, srcb1, pcsrc1, m2r1, rdst1;
  logic [3:0] aluop1, state1;

  ctl_t obs0, obs1, exp0, exp1;
  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic halted1 = 1'b0;
  logic [31:0] trace;
  logic [3:0]  alu2;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .OpCode(opcode), .Funct(funct),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mr0),
    .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0), .ExtOp(ext0), .LuiOp(lui0),
    .ALUSrcA(srca0), .ALUSrcB(srcb0), .PCSource(pcsrc0), .MemtoReg(m2r0),
    .RegDst(rdst0), .ALUOp(aluop0), .Illegal(ill0), .State(state0)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .OpCode(opcode), .Funct(funct),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1),
    .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1), .ExtOp(ext1), .LuiOp(lui1),
    .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCSource(pcsrc1), .MemtoReg(m2r1),
    .RegDst(rdst1), .ALUOp(aluop1), .Illegal(ill1), .State(state1)
  );

  assign obs0 = {pcw0, pcwc0, iord0, mr0, mw0, irw0, rw0, ext0, lui0,
                 srca0, srcb0, pcsrc0, m2r0, rdst0, aluop0, ill0, state0};
  assign obs1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, rw1, ext1, lui1,
                 srca1, srcb1, pcsrc1, m2r1, rdst1, aluop1, ill1, state1};

  // Instruction classes: 0 illegal, 1 lw, 2 sw, 3 R-type ALU, 4 I-type ALU, 5 beq, 6 j/jal, 7 jr/jalr
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 1;
      6'h2B: return 2;
      6'h00: return (fn == 6'h08 || fn == 6'h09) ? 7 : 3;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: return 4;
      6'h04: return 5;
      6'h02, 6'h03: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int nsteps(input logic [5:0] op, input logic [5:0] fn);
    case (cls(op, fn))
      0: return 2;
      1: return 5;
      2, 3, 4: return 4;
      default: return 3;
    endcase
  endfunction

  // Expected control word for cycle k of an instruction, derived from its class.
  function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn, input int k);
    ctl_t w;
    int c;
    w = '0;
    c = cls(op, fn);
    if (k == 0) begin
      w.st = 4'd1; w.mr = 1'b1; w.irw = 1'b1; w.srcb = 2'b01; w.pcw = 1'b1;
    end else if (k == 1) begin
      w.st = 4'd2; w.srcb = 2'b11; w.ext = 1'b1; w.ill = (c == 0);
    end else begin
      case (c)
        1, 2: begin
          if (k == 2) begin
            w.st = 4'd3; w.srca = 2'b01; w.srcb = 2'b10; w.ext = 1'b1;
          end else if (c == 2) begin
            w.st = 4'd6; w.mw = 1'b1; w.iord = 1'b1;
          end else if (k == 3) begin
            w.st = 4'd4; w.mr = 1'b1; w.iord = 1'b1;
          end else begin
            w.st = 4'd5; w.rw = 1'b1; w.m2r = 2'b01;
          end
        end
        3: begin
          if (k == 2) begin
            w.st = 4'd7; w.aluop = 4'b0010;
            w.srca = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
          end else begin
            w.st = 4'd8; w.rw = 1'b1; w.rdst = 2'b01;
          end
        end
        4: begin
          if (k == 2) begin
            w.st = 4'd9; w.srca = 2'b01; w.srcb = 2'b10;
            w.ext = (op != 6'h0C); w.lui = (op == 6'h0F);
            case (op)
              6'h09: w.aluop = 4'b1000;
              6'h0A: w.aluop = 4'b0101;
              6'h0B: w.aluop = 4'b1101;
              6'h0C: w.aluop = 4'b0100;
              default: w.aluop = 4'b0000;
            endcase
          end else begin
            w.st = 4'd10; w.rw = 1'b1;
          end
        end
        5: begin
          w.st = 4'd11; w.srca = 2'b01; w.aluop = 4'b0001; w.pcwc = 1'b1; w.pcsrc = 2'b01;
        end
        6: begin
          w.st = 4'd12; w.pcw = 1'b1; w.pcsrc = 2'b10;
          if (op == 6'h03) begin w.rw = 1'b1; w.rdst = 2'b10; w.m2r = 2'b10; end
        end
        default: begin
          w.st = 4'd13; w.pcw = 1'b1; w.pcsrc = 2'b11;
          if (fn == 6'h09) begin w.rw = 1'b1; w.rdst = 2'b01; w.m2r = 2'b10; end
        end
      endcase
    end
    return w;
  endfunction

  function automatic ctl_t halt_word();
    ctl_t w;
    w = '0;
    w.st = 4'd14;
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 2;
      if (obs0 !== exp0) begin
        failures = failures + 1;
        $display("FAIL cycle_dut0 t=%0t actual=%h required=%h", $time, obs0, exp0);
      end
      if (obs1 !== exp1) begin
        failures = failures + 1;
        $display("FAIL cycle_dut1 t=%0t actual=%h required=%h", $time, obs1, exp1);
      end
      if ((pcw0 && pcwc0) || (mr0 && mw0) || (pcw1 && pcwc1) || (mr1 && mw1)) begin
        failures = failures + 1;
        $display("FAIL exclusive_strobes t=%0t", $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks = checks + 1;
    if (actual !== required) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic run_n(input logic [5:0] op, input logic [5:0] fn, input int n);
    trace = '0;
    alu2  = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        opcode = op;
        funct  = fn;
      end
      exp0  = model(op, fn, k);
      exp1  = halted1 ? halt_word() : model(op, fn, k);
      trace = {trace[27:0], state0};
      if (k == 2) alu2 = aluop0;
    end
    if (n == nsteps(op, fn) && cls(op, fn) == 0) halted1 = 1'b1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn);
    run_n(op, fn, nsteps(op, fn));
  endtask

  initial begin
    reset  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    exp0   = '0;
    exp1   = '0;
    #1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {28'h0, state0}, 32'd0);
    check("reset_outputs", {4'h0, obs0}, 32'h0);
    reset = 1'b1;

    run(6'h23, 6'h00);
    check("lw_trace", trace, 32'h00012345);
    run(6'h00, 6'h00);
    check("sll_aluop", {28'h0, alu2}, 32'h2);
    run(6'h00, 6'h20);
    check("add_trace", trace, 32'h00001278);
    run(6'h0B, 6'h00);
    check("sltiu_aluop", {28'h0, alu2}, 32'hD);
    check("sltiu_trace", trace, 32'h0000129A);
    run(6'h0C, 6'h00);
    check("andi_aluop", {28'h0, alu2}, 32'h4);
    run(6'h0F, 6'h00);
    run(6'h08, 6'h00);
    run(6'h09, 6'h00);
    run(6'h0A, 6'h00);
    run(6'h2B, 6'h00);
    check("sw_trace", trace, 32'h00001236);
    run(6'h04, 6'h00);
    check("beq_trace", trace, 32'h0000012B);
    run(6'h02, 6'h00);
    run(6'h03, 6'h00);
    check("jal_trace", trace, 32'h0000012C);
    run(6'h00, 6'h08);
    run(6'h00, 6'h09);
    check("jalr_trace", trace, 32'h0000012D);
    run(6'h00, 6'h02);
    run(6'h00, 6'h03);

    run(6'h3F, 6'h00);
    check("illegal_trace", trace, 32'h00000012);
    run(6'h08, 6'h00);
    check("halt_held", {28'h0, state1}, 32'd14);

    run_n(6'h23, 6'h00, 4);
    #1;
    check("mr_reached", {27'h0, mr0, state0}, 32'h14);
    reset = 1'b0;
    exp0  = '0;
    exp1  = '0;
    #1;
    check("async_reset_state0", {27'h0, mr0, state0}, 32'h0);
    check("async_reset_state1", {28'h0, state1}, 32'h0);
    halted1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
